div_unit: RTL



---
 rtl/div_unit.sv | 138 +++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle restoring radix-2 divider (DIV/DIVU/REM/REMU)
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BYZERO, RUN, DONE} state_t;

  state_t             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [WIDTH-1:0]   rem_q, rem_n, quo_q, quo_n, dvs_q, dvs_n;
  logic               sgn1_q, sgn1_n, sgn2_q, sgn2_n, sdiv_q, sdiv_n;
  logic [2*WIDTH-1:0] result_n;
  logic               ready_n;

  logic               neg1, neg2;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   trial;
  logic [WIDTH-1:0]   quo_step, rem_step, quo_fix, rem_fix;

  assign neg1 = signed_div_i & opdata1_i[WIDTH-1];
  assign neg2 = signed_div_i & opdata2_i[WIDTH-1];
  assign abs1 = neg1 ? -opdata1_i : opdata1_i;
  assign abs2 = neg2 ? -opdata2_i : opdata2_i;

  // Trial subtraction on {rem,quo} shifted left; a borrow in the top bit means restore.
  assign shifted  = {rem_q, quo_q[WIDTH-1]};
  assign trial    = {1'b0, shifted} - {2'b00, dvs_q};
  assign quo_step = {quo_q[WIDTH-2:0], ~trial[WIDTH+1]};
  assign rem_step = trial[WIDTH+1] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];

  assign quo_fix = (sdiv_q & (sgn1_q ^ sgn2_q)) ? -quo_step : quo_step;
  assign rem_fix = (sdiv_q & sgn1_q) ? -rem_step : rem_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      sgn1_q   <= 1'b0;
      sgn2_q   <= 1'b0;
      sdiv_q   <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      rem_q    <= rem_n;
      quo_q    <= quo_n;
      dvs_q    <= dvs_n;
      sgn1_q   <= sgn1_n;
      sgn2_q   <= sgn2_n;
      sdiv_q   <= sdiv_n;
      result_o <= result_n;
      ready_o  <= ready_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rem_n    = rem_q;
    quo_n    = quo_q;
    dvs_n    = dvs_q;
    sgn1_n   = sgn1_q;
    sgn2_n   = sgn2_q;
    sdiv_n   = sdiv_q;
    result_n = result_o;
    ready_n  = ready_o;

    if (annul_i && state != IDLE) begin
      state_n  = IDLE;
      ready_n  = 1'b0;
      result_n = '0;
    end else begin
      case (state)
        IDLE: begin
          ready_n  = 1'b0;
          result_n = '0;
          if (start_i && !annul_i) begin
            sdiv_n = signed_div_i;
            sgn1_n = neg1;
            sgn2_n = neg2;
            cnt_n  = '0;
            rem_n  = '0;
            if (opdata2_i == '0) begin
              // Raw dividend is parked in quo for the RISC-V divide-by-zero remainder.
              state_n = BYZERO;
              quo_n   = opdata1_i;
            end else begin
              state_n = RUN;
              quo_n   = abs1;
              dvs_n   = abs2;
            end
          end
        end
        BYZERO: begin
          state_n  = DONE;
          ready_n  = 1'b1;
          result_n = {quo_q, {WIDTH{1'b1}}};
        end
        RUN: begin
          rem_n = rem_step;
          quo_n = quo_step;
          cnt_n = cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state_n  = DONE;
            ready_n  = 1'b1;
            result_n = {rem_fix, quo_fix};
          end
        end
        DONE: begin
          if (!start_i) begin
            state_n  = IDLE;
            ready_n  = 1'b0;
            result_n = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule
